// File: rtl/opn_sound_core.sv
// Simplified OPN sound core: register file, timers A/B with IRQ,
// 3-channel square PSG with I/O ports, 3-channel square FM, PCM/PWM mix.
//
// Ports:
//   rst, clk_in, cen          sync active-high reset, clock, clock enable
//   din, addr, cs_n, wr_n     CPU write bus (addr 0 = address, 1 = data)
//   dout, irq_n               read data (status / PSG reg), interrupt
//   IOA_*, IOB_*              PSG I/O ports (regs 0x0E/0x0F, oe from reg7)
//   psg_A/B/C, psg_snd        PSG channel levels and unsigned sum
//   fm_snd, snd, snd_pwm      signed FM mix, saturated total, sigma-delta bit
//   snd_sample, debug_view    sample strobe, latched register address
module opn_sound_core #(
    parameter int SAMPLE_DIV = 72,
    parameter int PSG_DIV    = 8
) (
    input  logic        rst,
    input  logic        clk_in,
    input  logic        cen,
    input  logic [7:0]  din,
    input  logic        addr,
    input  logic        cs_n,
    input  logic        wr_n,
    output logic [7:0]  dout,
    output logic        irq_n,
    input  logic [7:0]  IOA_in,
    input  logic [7:0]  IOB_in,
    output logic [7:0]  IOA_out,
    output logic [7:0]  IOB_out,
    output logic        IOA_oe,
    output logic        IOB_oe,
    output logic [7:0]  psg_A,
    output logic [7:0]  psg_B,
    output logic [7:0]  psg_C,
    output logic [15:0] fm_snd,
    output logic [9:0]  psg_snd,
    output logic [15:0] snd,
    output logic        snd_pwm,
    output logic        snd_sample,
    output logic [7:0]  debug_view
);
    localparam int SW = $clog2(SAMPLE_DIV + 1);
    localparam int PW = $clog2(PSG_DIV + 1);

    logic [7:0]       addr_q, addr_d;
    logic [15:0][7:0] psg_q, psg_d;
    logic [9:0]       ta_q, ta_d, ta_cnt_q, ta_cnt_d;
    logic [7:0]       tb_q, tb_d, tb_cnt_q, tb_cnt_d;
    logic [3:0]       presc_q, presc_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic [SW-1:0]    smp_cnt_q, smp_cnt_d;
    logic [PW-1:0]    psg_cnt_q, psg_cnt_d;
    logic [2:0][11:0] tone_cnt_q, tone_cnt_d;
    logic [2:0]       sq_q, sq_d;
    logic [2:0][10:0] fnum_q, fnum_d;
    logic [2:0][2:0]  blk_q, blk_d;
    logic [2:0][5:0]  hi_buf_q, hi_buf_d;
    logic [2:0][6:0]  tl_q, tl_d;
    logic [2:0]       key_q, key_d;
    logic [2:0][19:0] phase_q, phase_d;
    logic [2:0][7:0]  lvl_q, lvl_d;
    logic [15:0]      fm_snd_q, fm_snd_d;
    logic [9:0]       psg_snd_q, psg_snd_d;
    logic [15:0]      snd_q, snd_d;
    logic [7:0]       dout_q, dout_d;
    logic             irq_n_q, irq_n_d;
    logic             smp_q, smp_d;
    logic [15:0]      pwm_acc_q, pwm_acc_d;
    logic             pwm_q, pwm_d;

    logic             wr_a, wr_d, tick, psg_tick;
    logic             clr_a, clr_b, set_a, set_b;
    logic [7:0]       status;
    logic signed [17:0] amp, fm_sum, mix;

    function automatic logic [11:0] tone_per(input logic [7:0] hi, input logic [7:0] lo);
        logic [11:0] p;
        p = {hi[3:0], lo};
        return (p == 12'd0) ? 12'd1 : p;
    endfunction

    always_comb begin
        addr_d     = addr_q;
        psg_d      = psg_q;
        ta_d       = ta_q;
        tb_d       = tb_q;
        ta_cnt_d   = ta_cnt_q;
        tb_cnt_d   = tb_cnt_q;
        presc_d    = presc_q;
        ctrl_d     = ctrl_q;
        smp_cnt_d  = smp_cnt_q;
        psg_cnt_d  = psg_cnt_q;
        tone_cnt_d = tone_cnt_q;
        sq_d       = sq_q;
        fnum_d     = fnum_q;
        blk_d      = blk_q;
        hi_buf_d   = hi_buf_q;
        tl_d       = tl_q;
        key_d      = key_q;
        phase_d    = phase_q;
        fm_snd_d   = fm_snd_q;
        dout_d     = dout_q;
        clr_a      = 1'b0;
        clr_b      = 1'b0;
        set_a      = 1'b0;
        set_b      = 1'b0;
        amp        = '0;
        fm_sum     = '0;

        wr_a     = cen & ~cs_n & ~wr_n & ~addr;
        wr_d     = cen & ~cs_n & ~wr_n & addr;
        tick     = cen && (smp_cnt_q == SW'(SAMPLE_DIV - 1));
        psg_tick = cen && (psg_cnt_q == PW'(PSG_DIV - 1));
        smp_d    = tick;

        if (wr_a) addr_d = din;

        if (wr_d) begin
            if (addr_q[7:4] == 4'h0) psg_d[addr_q[3:0]] = din;
            case (addr_q)
                8'h24: ta_d[9:2] = din;
                8'h25: ta_d[1:0] = din[1:0];
                8'h26: tb_d = din;
                8'h27: begin
                    ctrl_d = din[3:0];
                    clr_a  = din[4];
                    clr_b  = din[5];
                end
                default: ;
            endcase
            for (int n = 0; n < 3; n++) begin
                if (addr_q == 8'h28 && din[1:0] == 2'(n)) key_d[n] = din[7];
                if (addr_q[1:0] == 2'(n)) begin
                    if (addr_q[7:2] == 6'b101001) hi_buf_d[n] = din[5:0];
                    // fnum high/block only take effect with the low byte
                    if (addr_q[7:2] == 6'b101000) begin
                        fnum_d[n] = {hi_buf_q[n][2:0], din};
                        blk_d[n]  = hi_buf_q[n][5:3];
                    end
                    if (addr_q[7:2] == 6'b010011) tl_d[n] = din[6:0];
                end
            end
        end

        if (cen) begin
            smp_cnt_d = tick ? '0 : smp_cnt_q + 1'b1;
            psg_cnt_d = psg_tick ? '0 : psg_cnt_q + 1'b1;

            if (!ctrl_q[0]) begin
                ta_cnt_d = ta_q;
            end else if (tick) begin
                if (ta_cnt_q == 10'h3FF) begin
                    ta_cnt_d = ta_q;
                    set_a    = 1'b1;
                end else begin
                    ta_cnt_d = ta_cnt_q + 10'd1;
                end
            end

            // prescaler restarts on load so B fires 16*(256-TB) ticks later
            if (!ctrl_q[1]) begin
                tb_cnt_d = tb_q;
                presc_d  = 4'd0;
            end else if (tick) begin
                presc_d = presc_q + 4'd1;
                if (presc_q == 4'hF) begin
                    if (tb_cnt_q == 8'hFF) begin
                        tb_cnt_d = tb_q;
                        set_b    = 1'b1;
                    end else begin
                        tb_cnt_d = tb_cnt_q + 8'd1;
                    end
                end
            end

            if (psg_tick) begin
                for (int n = 0; n < 3; n++) begin
                    if (tone_cnt_q[n] >= tone_per(psg_q[2*n+1], psg_q[2*n])) begin
                        tone_cnt_d[n] = 12'd0;
                        sq_d[n]       = ~sq_q[n];
                    end else begin
                        tone_cnt_d[n] = tone_cnt_q[n] + 12'd1;
                    end
                end
            end

            if (tick) begin
                for (int n = 0; n < 3; n++) begin
                    phase_d[n] = phase_q[n] + (20'(fnum_q[n]) << blk_q[n]);
                    amp = signed'({5'b0, 7'd127 - tl_q[n], 6'b0});
                    if (key_q[n]) fm_sum = fm_sum + (phase_d[n][19] ? -amp : amp);
                end
                fm_snd_d = fm_sum[15:0];
            end
        end

        // set wins over a clear in the same cycle
        flag_a_d = (flag_a_q & ~clr_a) | set_a;
        flag_b_d = (flag_b_q & ~clr_b) | set_b;
        irq_n_d  = ~((flag_a_d & ctrl_d[2]) | (flag_b_d & ctrl_d[3]));
        status   = {6'b0, flag_b_d, flag_a_d};

        for (int n = 0; n < 3; n++) begin
            lvl_d[n] = (!psg_d[7][n] && !sq_d[n]) ? 8'h00 : {psg_d[8+n][3:0], 4'h0};
        end
        psg_snd_d = 10'(lvl_d[0]) + 10'(lvl_d[1]) + 10'(lvl_d[2]);

        mix = $signed({{2{fm_snd_d[15]}}, fm_snd_d}) + $signed({4'b0, psg_snd_d, 4'b0});
        if (mix[17:15] == 3'b000 || mix[17:15] == 3'b111) snd_d = mix[15:0];
        else snd_d = mix[17] ? 16'h8000 : 16'h7FFF;

        if (cen) begin
            if (!addr || addr_d[7:4] != 4'h0) begin
                dout_d = status;
            end else begin
                dout_d = psg_d[addr_d[3:0]];
                if (addr_d == 8'h0E && !psg_d[7][6]) dout_d = IOA_in;
                if (addr_d == 8'h0F && !psg_d[7][7]) dout_d = IOB_in;
            end
        end

        // offset-binary input; carry out is the density-modulated bit
        {pwm_d, pwm_acc_d} = {1'b0, pwm_acc_q} + {1'b0, snd_q ^ 16'h8000};
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            addr_q     <= '0;
            psg_q      <= '0;
            ta_q       <= '0;
            tb_q       <= '0;
            ta_cnt_q   <= '0;
            tb_cnt_q   <= '0;
            presc_q    <= '0;
            ctrl_q     <= '0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            smp_cnt_q  <= '0;
            psg_cnt_q  <= '0;
            tone_cnt_q <= '0;
            sq_q       <= '0;
            fnum_q     <= '0;
            blk_q      <= '0;
            hi_buf_q   <= '0;
            tl_q       <= '0;
            key_q      <= '0;
            phase_q    <= '0;
            lvl_q      <= '0;
            fm_snd_q   <= '0;
            psg_snd_q  <= '0;
            snd_q      <= '0;
            dout_q     <= '0;
            irq_n_q    <= 1'b1;
            smp_q      <= 1'b0;
            pwm_acc_q  <= '0;
            pwm_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            psg_q      <= psg_d;
            ta_q       <= ta_d;
            tb_q       <= tb_d;
            ta_cnt_q   <= ta_cnt_d;
            tb_cnt_q   <= tb_cnt_d;
            presc_q    <= presc_d;
            ctrl_q     <= ctrl_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            smp_cnt_q  <= smp_cnt_d;
            psg_cnt_q  <= psg_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            sq_q       <= sq_d;
            fnum_q     <= fnum_d;
            blk_q      <= blk_d;
            hi_buf_q   <= hi_buf_d;
            tl_q       <= tl_d;
            key_q      <= key_d;
            phase_q    <= phase_d;
            lvl_q      <= lvl_d;
            fm_snd_q   <= fm_snd_d;
            psg_snd_q  <= psg_snd_d;
            snd_q      <= snd_d;
            dout_q     <= dout_d;
            irq_n_q    <= irq_n_d;
            smp_q      <= smp_d;
            pwm_acc_q  <= pwm_acc_d;
            pwm_q      <= pwm_d;
        end
    end

    assign dout       = dout_q;
    assign irq_n      = irq_n_q;
    assign IOA_out    = psg_q[14];
    assign IOB_out    = psg_q[15];
    assign IOA_oe     = psg_q[7][6];
    assign IOB_oe     = psg_q[7][7];
    assign psg_A      = lvl_q[0];
    assign psg_B      = lvl_q[1];
    assign psg_C      = lvl_q[2];
    assign fm_snd     = fm_snd_q;
    assign psg_snd    = psg_snd_q;
    assign snd        = snd_q;
    assign snd_pwm    = pwm_q;
    assign snd_sample = smp_q;
    assign debug_view = addr_q;
endmodule

// File: tb/tb_opn_sound_core.sv
// Directed bench for opn_sound_core: reset, timers, PSG tones,
// FM square voice, mix saturation and I/O ports.
module tb_opn_sound_core;
    logic        clk = 1'b0;
    logic        rst, cen, addr, cs_n, wr_n;
    logic [7:0]  din, dout, IOA_in, IOB_in, IOA_out, IOB_out;
    logic        irq_n, IOA_oe, IOB_oe, snd_pwm, snd_sample;
    logic [7:0]  psg_A, psg_B, psg_C, debug_view;
    logic [15:0] fm_snd, snd;
    logic [9:0]  psg_snd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    opn_sound_core dut (
        .rst(rst), .clk_in(clk), .cen(cen), .din(din), .addr(addr),
        .cs_n(cs_n), .wr_n(wr_n), .dout(dout), .irq_n(irq_n),
        .IOA_in(IOA_in), .IOB_in(IOB_in), .IOA_out(IOA_out),
        .IOB_out(IOB_out), .IOA_oe(IOA_oe), .IOB_oe(IOB_oe),
        .psg_A(psg_A), .psg_B(psg_B), .psg_C(psg_C), .fm_snd(fm_snd),
        .psg_snd(psg_snd), .snd(snd), .snd_pwm(snd_pwm),
        .snd_sample(snd_sample), .debug_view(debug_view)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    task automatic wr_port(input logic a, input logic [7:0] d);
        addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        step(1);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] r, input logic [7:0] d);
        wr_port(1'b0, r);
        wr_port(1'b1, d);
    endtask

    task automatic rd(input logic a);
        addr = a;
        step(1);
    endtask

    task automatic wait_smp();
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (snd_sample) break;
        end
        check("smp_seen", {31'd0, snd_sample}, 32'd1);
    endtask

    task automatic wait_lvl(input logic [7:0] v);
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (psg_A == v) break;
        end
        check("psgA_lvl", {24'd0, psg_A}, {24'd0, v});
    endtask

    task automatic measure_half(output int n);
        logic [7:0] prev;
        prev = psg_A;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (psg_A != prev) break;
        end
        prev = psg_A;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            n++;
            if (psg_A != prev) break;
        end
    endtask

    initial begin
        int ones;
        int half;
        rst = 1'b1; cen = 1'b1; addr = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
        din = 8'h00; IOA_in = 8'hC3; IOB_in = 8'h3C;

        // reset state
        step(7);
        check("rst_irq_n", {31'd0, irq_n}, 32'd1);
        check("rst_fm", {16'd0, fm_snd}, 32'd0);
        check("rst_psg", {22'd0, psg_snd}, 32'd0);
        check("rst_snd", {16'd0, snd}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_pwm", {31'd0, snd_pwm}, 32'd0);
        check("rst_dbg", {24'd0, debug_view}, 32'd0);
        rst = 1'b0;

        // snd = 0 is mid-scale: sigma-delta density one half
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            ones += int'(snd_pwm);
        end
        check("pwm_mid", ones, 32'd50);

        // timer A
        rd(1'b0);
        check("stat0", {24'd0, dout}, 32'd0);
        wr_reg(8'h24, 8'hFF);
        wr_reg(8'h25, 8'h03);
        wr_reg(8'h27, 8'h05);
        check("irqA_pre", {31'd0, irq_n}, 32'd1);
        wait_smp();
        check("irqA_set", {31'd0, irq_n}, 32'd0);
        rd(1'b0);
        check("statA", {24'd0, dout}, 32'h01);
        rd(1'b1);
        check("statA_hi", {24'd0, dout}, 32'h01);
        wr_reg(8'h27, 8'h15);
        check("irqA_clr", {31'd0, irq_n}, 32'd1);
        rd(1'b0);
        check("statA_clr", {24'd0, dout}, 32'h00);
        wait_smp();
        check("irqA_again", {31'd0, irq_n}, 32'd0);

        // timer B: 16 sample ticks from load
        wr_reg(8'h26, 8'hFF);
        wr_reg(8'h27, 8'h3B);
        for (int i = 1; i <= 16; i++) begin
            wait_smp();
            if (i == 15) check("irqB_15", {31'd0, irq_n}, 32'd1);
        end
        check("irqB_16", {31'd0, irq_n}, 32'd0);
        rd(1'b0);
        check("statAB", {24'd0, dout}, 32'h03);

        // PSG tone A, B tone off with volume 5
        do_reset(2);
        wr_reg(8'h00, 8'h01);
        wr_reg(8'h01, 8'h00);
        wr_reg(8'h07, 8'h3E);
        wr_reg(8'h08, 8'h1F);
        wr_reg(8'h09, 8'h05);
        step(2);
        check("psgB", {24'd0, psg_B}, 32'h50);
        check("psgC", {24'd0, psg_C}, 32'h00);
        measure_half(half);
        check("half_p1", half, 32'd16);
        wait_lvl(8'hF0);
        check("psg_hi", {22'd0, psg_snd}, 32'h140);
        check("snd_hi", {16'd0, snd}, 32'h1400);
        wait_lvl(8'h00);
        check("psg_lo", {22'd0, psg_snd}, 32'h050);
        check("snd_lo", {16'd0, snd}, 32'h0500);
        wr_reg(8'h00, 8'h03);
        measure_half(half);
        check("half_p3", half, 32'd32);
        wr_reg(8'h00, 8'h00);
        measure_half(half);
        check("half_p0", half, 32'd16);

        // FM channel 0: increment 0x269<<4 = 9872 per tick
        do_reset(2);
        wr_reg(8'h4C, 8'h00);
        wr_reg(8'hA4, 8'h22);
        wait_smp();
        wr_reg(8'hA0, 8'h69);
        wr_reg(8'h28, 8'h80);
        for (int k = 1; k <= 54; k++) begin
            wait_smp();
            if (k == 1) begin
                check("fm_k1", {16'd0, fm_snd}, 32'h1FC0);
                check("snd_k1", {16'd0, snd}, 32'h1FC0);
            end
            if (k == 53) check("fm_k53", {16'd0, fm_snd}, 32'h1FC0);
        end
        check("fm_k54", {16'd0, fm_snd}, 32'hE040);
        check("snd_k54", {16'd0, snd}, 32'hE040);
        wr_reg(8'h4C, 8'h3F);
        check("fm_hold", {16'd0, fm_snd}, 32'hE040);
        wait_smp();
        check("fm_tl3f", {16'd0, fm_snd}, 32'hF000);
        wr_reg(8'h28, 8'h00);
        wait_smp();
        check("fm_keyoff", {16'd0, fm_snd}, 32'h0000);
        wr_reg(8'h28, 8'h83);
        wait_smp();
        check("fm_ch3", {16'd0, fm_snd}, 32'h0000);

        // full-scale mix saturates
        do_reset(2);
        wr_reg(8'h28, 8'h80);
        wr_reg(8'h28, 8'h81);
        wr_reg(8'h28, 8'h82);
        wr_reg(8'h07, 8'h3F);
        wr_reg(8'h08, 8'h0F);
        wr_reg(8'h09, 8'h0F);
        wr_reg(8'h0A, 8'h0F);
        wait_smp();
        check("fm_max", {16'd0, fm_snd}, 32'h5F40);
        check("psg_max", {22'd0, psg_snd}, 32'h2D0);
        check("snd_sat", {16'd0, snd}, 32'h7FFF);

        // I/O ports
        wr_reg(8'h0E, 8'h5A);
        wr_reg(8'h07, 8'h40);
        check("ioa_out", {24'd0, IOA_out}, 32'h5A);
        check("ioa_oe", {31'd0, IOA_oe}, 32'd1);
        check("iob_oe", {31'd0, IOB_oe}, 32'd0);
        wr_port(1'b0, 8'h0E);
        rd(1'b1);
        check("rd_0e_out", {24'd0, dout}, 32'h5A);
        wr_reg(8'h07, 8'h00);
        wr_port(1'b0, 8'h0E);
        rd(1'b1);
        check("rd_0e_in", {24'd0, dout}, 32'hC3);
        wr_port(1'b0, 8'h0F);
        rd(1'b1);
        check("rd_0f_in", {24'd0, dout}, 32'h3C);
        check("dbg_0f", {24'd0, debug_view}, 32'h0F);
        wr_port(1'b0, 8'h08);
        rd(1'b1);
        check("rd_08", {24'd0, dout}, 32'h0F);

        // writes ignored without cen
        cen = 1'b0;
        wr_reg(8'h0E, 8'h11);
        cen = 1'b1;
        step(1);
        check("cen_ioa", {24'd0, IOA_out}, 32'h5A);
        check("cen_dbg", {24'd0, debug_view}, 32'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
